uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
- Transmit controller for the UART.
- Consumes the single-cycle 16x-oversampling tick from the baud generator and sequences one 8N1 frame (start bit, data LSB first, stop bit) onto the serial line.
- Sits between the baud generator and the user logic, which hands over bytes with a start/busy/done handshake.

Parameters:
- DATA_BITS, 8, number of data bits per frame, sent LSB first.
- SAMPLES, 16, baud ticks per bit period. Must match the baud generator's oversampling factor.
- STOP_TICKS, 16, baud ticks the stop bit is held high. Must be at least 1.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-low reset (0 = reset).
- tick  input  1  one-clk pulse from the baud generator, SAMPLES pulses per bit.
- tx_start  input  1  request to send tx_data. Sampled only in IDLE.
- tx_data  input  DATA_BITS  byte to send. Captured in the cycle tx_start is accepted.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high from the cycle after acceptance until return to IDLE.
- tx_done  output  1  one-clk pulse when the stop bit completes.

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=IDLE; tx=1, tx_busy=0, tx_done=0.
  - Tick counter, bit counter and shift register cleared.
  - Applies mid-frame as well: the frame is abandoned and the line returns high on the next edge.
- States: IDLE, START, DATA, STOP. All outputs are registered.
- Tick counter:
  - Width is clog2(max(SAMPLES, STOP_TICKS)).
  - Increments only on cycles with tick==1 in START, DATA and STOP.
  - Never advances on clk alone.
- Bit counter: clog2(DATA_BITS) wide.
- IDLE:
  - tx=1.
  - If tx_start==1: capture tx_data into the shift register, clear both counters, go to START. tx=0 and tx_busy=1 from the next edge.
  - A tick in the same cycle is not counted.
- START:
  - tx=0.
  - On the tick with tick counter==SAMPLES-1: clear the counter, go to DATA, put shift[0] on tx.
  - Start bit length is 15 full tick periods plus the partial period up to the first tick. No realignment to the tick phase.
- DATA:
  - tx=shift[0].
  - On the tick with tick counter==SAMPLES-1: clear the counter and shift right by one.
  - If bit counter==DATA_BITS-1: go to STOP with tx=1. Otherwise increment the bit counter and present the next bit.
- STOP:
  - tx=1.
  - On the tick with tick counter==STOP_TICKS-1: go to IDLE, tx_busy=0, tx_done=1 for exactly one clk.
- Back-to-back: tx_start may be high in the cycle tx_done is asserted (state already IDLE). It is accepted normally, so there are no idle-high cycles beyond the stop bit.
- tx_start while tx_busy==1 is ignored; no queuing. Changes on tx_data after acceptance do not affect the frame in flight.
- tick held high for consecutive clks is counted once per clk. The block is not required to detect this; it is the generator's contract to pulse.
- Frame length in ticks is SAMPLES*(1+DATA_BITS)+STOP_TICKS = 160 at the defaults. With the 100 MHz clock and a tick every 652 clks, that is about 104.3 k clk.

Test Plan:
- Reset / idle:
  - Stimulus: hold reset=0 for 3 clk with random tx_start/tick, then release with no tx_start.
  - Required: tx=1, tx_busy=0, tx_done=0 throughout; state IDLE.
- Single frame 0xA5:
  - Stimulus: bench tick every 4 clk; pulse tx_start with tx_data=0xA5.
  - Required: tx levels 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
  - Each level lasts 16 ticks, the start bit up to the first-tick phase.
  - tx_done pulses once, 1 clk wide; tx_busy falls in that same cycle.
- Busy rejection:
  - Stimulus: send 0x00; during DATA pulse tx_start with tx_data=0xFF.
  - Required: the frame stays all-zero data, and no second frame follows.
- Back-to-back:
  - Stimulus: hold tx_start=1 with 0x3C then 0xC3, changing data on tx_done.
  - Required: two contiguous frames; the stop bit of the first is exactly 16 ticks, followed immediately by the start bit of the second.
- Reset mid-frame:
  - Stimulus: assert reset=0 for 1 clk during data bit 3 of 0x55.
  - Required: tx=1 and tx_busy=0 on the next edge; no tx_done.
  - A new tx_start afterwards produces a full, correct frame.
- Start coincident with tick:
  - Stimulus: tx_start and tick in the same clk.
  - Required: the start bit spans 16 further ticks; that tick is not counted.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Brief    : UART transmit sequencer. Counts 16x-oversampling baud ticks and
//            shifts one start/data/stop frame out on tx with a
//            start/busy/done handshake toward the user logic.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int SAMPLES    = 16,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TICK_MAX = (SAMPLES > STOP_TICKS) ? SAMPLES : STOP_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] SAMPLE_LAST = TICK_W'(SAMPLES - 1);
  localparam logic [TICK_W-1:0] STOP_LAST   = TICK_W'(STOP_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [TICK_W-1:0]    tick_cnt, tick_cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 tx_nxt, busy_nxt, done_nxt;

  // State, counters, shift register and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
      tx_busy  <= busy_nxt;
      tx_done  <= done_nxt;
    end
  end

  // Next-state and next-output decode; counters only move on baud ticks.
  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    tx_nxt       = tx;
    busy_nxt     = tx_busy;
    done_nxt     = 1'b0;

    unique case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        // A tick coinciding with acceptance is deliberately not counted.
        if (tx_start) begin
          shift_nxt    = tx_data;
          tick_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          state_nxt    = START;
          tx_nxt       = 1'b0;
          busy_nxt     = 1'b1;
        end
      end

      START: begin
        tx_nxt = 1'b0;
        if (tick) begin
          if (tick_cnt == SAMPLE_LAST) begin
            tick_cnt_nxt = '0;
            state_nxt    = DATA;
            tx_nxt       = shift[0];
          end else begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end

      DATA: begin
        tx_nxt = shift[0];
        if (tick) begin
          if (tick_cnt == SAMPLE_LAST) begin
            tick_cnt_nxt = '0;
            shift_nxt    = shift >> 1;
            if (bit_cnt == BIT_LAST) begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end else begin
              bit_cnt_nxt = bit_cnt + BIT_W'(1);
              tx_nxt      = shift_nxt[0];
            end
          end else begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end

      STOP: begin
        tx_nxt = 1'b1;
        if (tick) begin
          if (tick_cnt == STOP_LAST) begin
            tick_cnt_nxt = '0;
            state_nxt    = IDLE;
            busy_nxt     = 1'b0;
            done_nxt     = 1'b1;
          end else begin
            tick_cnt_nxt = tick_cnt + TICK_W'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
